// File: rtl/legv8_pkg.sv
// Shared LEGv8 encodings: branch types, ARM condition codes and ALU status bit positions.
package legv8_pkg;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_CBZ  = 2'b10;
    localparam logic [1:0] BR_CBNZ = 2'b11;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Status and flags share the {V,C,N,Z} layout.
    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_C = 2;
    localparam int STAT_V = 3;

endpackage

// File: rtl/alu_flags_branch_stage_cond_eval.sv
// cond_eval: combinational ARM condition-code check against an NZCV value ({V,C,N,Z}).
module cond_eval
    import legv8_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);

    logic n, z, c, v;

    always_comb begin
        n = nzcv[STAT_N];
        z = nzcv[STAT_Z];
        c = nzcv[STAT_C];
        v = nzcv[STAT_V];
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_HS: taken = c;
            COND_LO: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~(c & ~z);
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = ~(~z & (n == v));
            // NV behaves as always in ARMv8.
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_flags_branch_stage.sv
// Execute-to-memory stage: registers ALU result, holds NZCV, resolves B.cond/CBZ/CBNZ.
// Optional taken-branch counter enabled by defining ALU_FLAGS_BRANCH_COUNT_EN.
module alu_flags_branch_stage
    import legv8_pkg::*;
#(
    parameter int N = 64
`ifdef ALU_FLAGS_BRANCH_COUNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [N-1:0]     F,
    input  logic [3:0]       status,
    input  logic             set_flags,
    input  logic [1:0]       br_type,
    input  logic [3:0]       cond,
    output logic             out_valid,
    output logic [N-1:0]     result,
    output logic             branch_taken,
`ifdef ALU_FLAGS_BRANCH_COUNT_EN
    output logic [CNT_W-1:0] taken_count,
`endif
    output logic [3:0]       flags
);

    logic cond_taken;
    logic taken_next;

    // B.cond looks at the flags register before this edge's update.
    cond_eval u_cond_eval (
        .cond  (cond),
        .nzcv  (flags),
        .taken (cond_taken)
    );

    always_comb begin
        taken_next = 1'b0;
        case (br_type)
            BR_COND: taken_next = cond_taken;
            BR_CBZ:  taken_next = status[STAT_Z];
            BR_CBNZ: taken_next = ~status[STAT_Z];
            default: taken_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid    <= 1'b0;
            result       <= '0;
            branch_taken <= 1'b0;
            flags        <= 4'b0000;
        end else if (!stall) begin
            result <= F;
            if (flush) begin
                out_valid    <= 1'b0;
                branch_taken <= 1'b0;
            end else begin
                out_valid    <= in_valid;
                branch_taken <= in_valid & taken_next;
                if (in_valid && set_flags)
                    flags <= status;
            end
        end
    end

`ifdef ALU_FLAGS_BRANCH_COUNT_EN
    // Saturating count of resolved taken branches.
    always_ff @(posedge clock) begin
        if (reset)
            taken_count <= '0;
        else if (!stall && !flush && in_valid && taken_next && !(&taken_count))
            taken_count <= taken_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_alu_flags_branch_stage.sv
// Scoreboard bench for alu_flags_branch_stage; counter checks active with ALU_FLAGS_BRANCH_COUNT_EN.
module tb_alu_flags_branch_stage;
    import legv8_pkg::*;

`ifdef ALU_FLAGS_BRANCH_COUNT_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 32;
`endif

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [63:0] F;
    logic [3:0]  status;
    logic        set_flags;
    logic [1:0]  br_type;
    logic [3:0]  cond;
    logic        out_valid;
    logic [63:0] result;
    logic        branch_taken;
    logic [3:0]  flags;
`ifdef ALU_FLAGS_BRANCH_COUNT_EN
    logic [TB_CNT_W-1:0] taken_count;
`endif

    alu_flags_branch_stage #(
        .N (64)
`ifdef ALU_FLAGS_BRANCH_COUNT_EN
        ,
        .CNT_W (TB_CNT_W)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .stall        (stall),
        .flush        (flush),
        .F            (F),
        .status       (status),
        .set_flags    (set_flags),
        .br_type      (br_type),
        .cond         (cond),
        .out_valid    (out_valid),
        .result       (result),
        .branch_taken (branch_taken),
`ifdef ALU_FLAGS_BRANCH_COUNT_EN
        .taken_count  (taken_count),
`endif
        .flags        (flags)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        v;
        logic [63:0] r;
        bit          rk;
        logic        t;
        logic [3:0]  fl;
        longint      cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Architectural view of the stage after each edge.
    logic        m_v   = 1'b0;
    logic [63:0] m_r   = '0;
    bit          m_rk  = 1'b0;
    logic        m_t   = 1'b0;
    logic [3:0]  m_fl  = 4'b0000;
    longint      m_cnt = 0;
    longint      cnt_max = (longint'(1) << TB_CNT_W) - 1;

    // ARM condition evaluation: pairs of conditions, odd code negates (except NV).
    function automatic bit ref_cond(input logic [3:0] cd, input logic [3:0] fl);
        bit fn, fz, fc, fv, r;
        fz = fl[0]; fn = fl[1]; fc = fl[2]; fv = fl[3];
        case (int'(cd) / 2)
            0: r = fz;
            1: r = fc;
            2: r = fn;
            3: r = fv;
            4: r = fc && !fz;
            5: r = (fn == fv);
            6: r = !fz && (fn == fv);
            default: r = 1'b1;
        endcase
        if ((int'(cd) % 2 == 1) && (int'(cd) != 15))
            r = !r;
        return r;
    endfunction

    function automatic bit ref_taken(input logic [1:0] bt, input logic [3:0] cd,
                                     input logic [3:0] stat, input logic [3:0] fl);
        if (bt == BR_COND) return ref_cond(cd, fl);
        if (bt == BR_CBZ)  return stat[0];
        if (bt == BR_CBNZ) return !stat[0];
        return 1'b0;
    endfunction

    task automatic drive(input bit rst, input bit v, input bit st, input bit fl,
                         input logic [63:0] f, input logic [3:0] stat, input bit sf,
                         input logic [1:0] bt, input logic [3:0] cd);
        exp_t e;
        bit tk;
        @(negedge clock);
        reset = rst; in_valid = v; stall = st; flush = fl; F = f;
        status = stat; set_flags = sf; br_type = bt; cond = cd;
        if (rst) begin
            m_v = 0; m_r = '0; m_rk = 1; m_t = 0; m_fl = 4'b0000; m_cnt = 0;
        end else if (st) begin
            // everything holds
        end else if (fl) begin
            m_v = 0; m_t = 0; m_rk = 0;
        end else begin
            tk = v && ref_taken(bt, cd, stat, m_fl);
            m_v = v; m_r = f; m_rk = 1; m_t = tk;
            if (v && sf) m_fl = stat;
            if (tk && m_cnt < cnt_max) m_cnt = m_cnt + 1;
        end
        e.v = m_v; e.r = m_r; e.rk = m_rk; e.t = m_t; e.fl = m_fl; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic op(input bit v, input logic [63:0] f, input logic [3:0] stat,
                      input bit sf, input logic [1:0] bt, input logic [3:0] cd);
        drive(0, v, 0, 0, f, stat, sf, bt, cd);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected snapshot per sampled edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", 64'(out_valid), 64'(e.v));
                check("branch_taken", 64'(branch_taken), 64'(e.t));
                check("flags", 64'(flags), 64'(e.fl));
                if (e.rk) check("result", result, e.r);
`ifdef ALU_FLAGS_BRANCH_COUNT_EN
                check("taken_count", 64'(taken_count), 64'(e.cnt));
`endif
            end
        end
    end

    initial begin
        reset = 1; in_valid = 1; stall = 0; flush = 0; F = 64'hFFFF;
        status = 4'hF; set_flags = 1; br_type = BR_COND; cond = COND_AL;

        // Reset held two cycles with live inputs.
        drive(1, 1, 0, 0, 64'hFFFF, 4'hF, 1, BR_COND, COND_AL);
        drive(1, 1, 0, 0, 64'hFFFF, 4'hF, 1, BR_COND, COND_AL);

        // SUBS setting Z and C, then B.EQ / B.NE.
        op(1, 64'h0, 4'b0101, 1, BR_NONE, COND_NE);
        op(1, 64'h10, 4'b0000, 0, BR_COND, COND_EQ);
        op(1, 64'h14, 4'b0000, 0, BR_COND, COND_NE);

        // Signed compares.
        op(1, 64'h1, 4'b1000, 1, BR_NONE, COND_EQ);
        op(1, 64'h2, 4'b0000, 0, BR_COND, COND_LT);
        op(1, 64'h3, 4'b0000, 0, BR_COND, COND_GE);
        op(1, 64'h4, 4'b0000, 1, BR_NONE, COND_EQ);
        op(1, 64'h5, 4'b1111, 0, BR_COND, COND_GT);
        op(1, 64'h6, 4'b1111, 0, BR_COND, COND_AL);
        op(1, 64'h7, 4'b1111, 0, BR_COND, COND_NV);

        // Back-to-back setters, B.cond immediately after.
        op(1, 64'h8, 4'b0010, 1, BR_NONE, COND_EQ);
        op(1, 64'h9, 4'b0001, 1, BR_NONE, COND_EQ);
        op(1, 64'hA, 4'b0000, 0, BR_COND, COND_EQ);

        // CBZ / CBNZ.
        op(1, 64'h0, 4'b0001, 0, BR_CBZ, COND_NE);
        op(1, 64'h5, 4'b0000, 0, BR_CBNZ, COND_EQ);
        op(1, 64'h0, 4'b0001, 0, BR_CBNZ, COND_AL);
        op(1, 64'h0, 4'b1100, 1, BR_CBZ, COND_AL);
        op(0, 64'hBEEF, 4'b0011, 1, BR_COND, COND_AL);

        // Stall for three cycles while inputs churn.
        op(1, 64'h1234, 4'b0110, 1, BR_COND, COND_AL);
        for (int i = 0; i < 3; i++)
            drive(0, 1, 1, 0, {$urandom, $urandom}, 4'($urandom), 1, BR_CBNZ, 4'($urandom));
        // Flush with a flag setter, then stall with flush.
        drive(0, 1, 0, 1, 64'h77, 4'b1001, 1, BR_COND, COND_AL);
        op(1, 64'h88, 4'b0000, 0, BR_COND, COND_AL);
        drive(0, 1, 1, 1, 64'h99, 4'b1111, 1, BR_NONE, COND_EQ);
        // Reset during a stall.
        drive(1, 1, 1, 0, 64'hAA, 4'b1111, 1, BR_COND, COND_AL);

        // Saturation of the taken counter, then a flushed taken branch.
        for (int i = 0; i < 17; i++)
            op(1, 64'(i), 4'b0000, 0, BR_COND, COND_AL);
        drive(1, 0, 0, 0, '0, '0, 0, BR_NONE, COND_EQ);
        op(1, 64'h1, 4'b0000, 0, BR_COND, COND_AL);
        drive(0, 1, 0, 1, 64'h2, 4'b0000, 0, BR_COND, COND_AL);
        drive(0, 1, 1, 0, 64'h3, 4'b0000, 0, BR_COND, COND_AL);
        op(1, 64'h4, 4'b0000, 0, BR_CBZ, COND_EQ);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                  {$urandom, $urandom}, 4'($urandom), 1'($urandom),
                  2'($urandom), 4'($urandom));
        end

        drive(0, 0, 0, 0, '0, '0, 0, BR_NONE, COND_EQ);
        @(negedge clock);
        @(negedge clock);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
